// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Unsigned shift-and-add multiplier, one partial product per clock.
//   A request is accepted in IDLE. RUN then performs xlen add/shift iterations
//   through a ripple-carry adder. DONE presents the exact 2*xlen-bit product
//   with a one-cycle done pulse.
//
// Ports
//   clk      : single clock, rising-edge active
//   rstn     : synchronous active-low reset
//   start    : begin a multiply (honoured only while ready=1)
//   a, b     : unsigned multiplicand / multiplier, sampled on the accepting edge
//   ready    : high only in IDLE
//   done     : one-cycle pulse, product valid in the same cycle
//   product  : a*b, held until the next completed operation
// -----------------------------------------------------------------------------

// ripple_carry_adder: plain width-bit ripple adder built from full-adder cells.
//   a, b : addends     cin  : carry in
//   sum  : result      cout : carry out of the MSB
module ripple_carry_adder #(
    parameter int width = 64
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    logic [width:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < width; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[width];

endmodule

module seq_multiplier #(
    parameter int xlen = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [xlen-1:0]   a,
    input  logic [xlen-1:0]   b,
    output logic              ready,
    output logic              done,
    output logic [2*xlen-1:0] product
);

    localparam int cw = (xlen > 1) ? $clog2(xlen) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [xlen-1:0]   multiplicand;
    logic [2*xlen-1:0] acc;
    logic [cw-1:0]     cnt;

    logic [xlen-1:0]   addend;
    logic [xlen-1:0]   sum;
    logic              carry;
    logic [2*xlen-1:0] acc_next;

    // The low half of acc starts as the multiplier; its LSB selects whether
    // this iteration adds the multiplicand into the upper half.
    assign addend = acc[0] ? multiplicand : '0;

    ripple_carry_adder #(
        .width (xlen)
    ) u_adder (
        .a    (acc[2*xlen-1:xlen]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // The adder carry becomes the new MSB, so nothing is lost across the shift.
    assign acc_next = {carry, sum, acc[xlen-1:1]};

    always_ff @(posedge clk) begin
        // NOTE: every register here, including the datapath, is cleared by
        // reset so an abandoned operation leaves product reading zero.
        if (!rstn) begin
            // NOTE: non-blocking assignments throughout so every register
            // samples the pre-edge values, whatever the statement order.
            state        <= IDLE;
            ready        <= 1'b1;
            done         <= 1'b0;
            product      <= '0;
            acc          <= '0;
            multiplicand <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        multiplicand <= a;
                        acc          <= {{xlen{1'b0}}, b};
                        cnt          <= '0;
                        ready        <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + cw'(1);
                    // cnt == xlen-1 marks the last of the xlen iterations.
                    if (cnt == cw'(xlen - 1)) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter xlen, default 64, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, honoured only while ready=1.
REQ-005 The block SHALL have port a, input, xlen bits: unsigned multiplicand, sampled on the accepting edge.
REQ-006 The block SHALL have port b, input, xlen bits: unsigned multiplier, sampled on the accepting edge.
REQ-007 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking product valid.
REQ-009 The block SHALL have port product, output, 2*xlen bits: unsigned result a*b.

Function
REQ-010 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 The block SHALL, in IDLE with start=1 at an edge, load M<=a, load acc<={xlen'b0, b}, clear iteration counter cnt<=0, and enter RUN.
REQ-012 The block SHALL, on each RUN edge, form {c, s} = acc[2*xlen-1:xlen] + (acc[0] ? M : 0) with carry_in=0, using an instantiated ripple_carry_adder of width xlen.
REQ-013 The block SHALL, on each RUN edge, update acc <= {c, s, acc[xlen-1:1]} (shift right by one, carry into MSB) and increment cnt.
REQ-014 The block SHALL leave RUN for DONE on the edge where cnt reaches xlen-1, that edge being the xlen-th iteration.
REQ-015 The block SHALL, on entering DONE, register acc into product; done=1 for exactly the one cycle spent in DONE.
REQ-016 The block SHALL, on the next edge after DONE, return unconditionally to IDLE; start is ignored in DONE.
REQ-017 The block SHALL give latency: start accepted at edge k leads to done high in the cycle after edge k+xlen, with product valid in that same cycle.
REQ-018 The block SHALL hold product stable from DONE until the next DONE; a new start does not alter product.
REQ-019 The block SHALL ignore start in RUN and DONE, with a, b, M and acc unaffected.
REQ-020 The block SHALL require a and b only on the accepting edge; they may change freely afterwards.
REQ-021 The block SHALL never overflow product, since the 2*xlen-bit result is exact for all unsigned operands.
REQ-022 The block SHALL accept a start issued in the first IDLE cycle after DONE, giving back-to-back throughput of one result per xlen+2 cycles.

Reset
REQ-023 The block SHALL, when rstn=0 at an edge, force state=IDLE, ready=1, done=0, product=0, acc=0, M=0, cnt=0.
REQ-024 The block SHALL treat reset as dominant over start in the same cycle; the operation is not accepted.
REQ-025 The block SHALL abandon any in-flight operation on reset mid-RUN or in DONE; no done pulse follows, and product reads 0.
REQ-026 The block SHALL keep ready=1 in the first cycle after rstn returns high and accept start on that cycle's edge.

Verification
REQ-027 The bench SHALL cover: a=0, b=0, start pulse -> done exactly xlen+1 cycles later, product=0, ready high the cycle after.
REQ-028 The bench SHALL cover: a=3, b=5 -> product=15, with done high for exactly one cycle at edge k+xlen.
REQ-029 The bench SHALL cover: a=all-ones, b=all-ones (xlen=64) -> product=0xFFFFFFFFFFFFFFFE_0000000000000001, checking the carry path into the upper half.
REQ-030 The bench SHALL cover: start a=7, b=6, then start a=2, b=2 in mid-RUN -> second start ignored, product=42.
REQ-031 The bench SHALL cover: start a=9, b=9, rstn=0 for one cycle at iteration xlen/2 -> no done, product=0, ready=1; then a=4, b=4 -> product=16.
REQ-032 The bench SHALL cover: back-to-back a=0x1_0000_0000 * b=0x1_0000_0000 then a=1 * b=-1 -> product=2^64, then product=0x0000000000000000_FFFFFFFFFFFFFFFF.
